rf_burst_reader: RTL and testbench

Burst read port for the 8-entry register file: accepts a start address and word count, then streams consecutive register contents out over a valid/ready interface, wrapping from the last register back to register 0. It is the read-side counterpart of the write-enable decode path. It sits between the register bank outputs and any consumer that drains registers sequentially, such as a dump or debug path. Output data is registered and frozen while stalled, so register writes during a stall never corrupt an in-flight word.

---
 rtl/rf_burst_reader_if.sv | 27 ++
 rtl/rf_burst_reader.sv | 99 +++++++++
 tb/tb_rf_burst_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rf_burst_reader_if.sv
// rtl/rf_burst_reader_if.sv - burst request and streamed read-out signals of rf_burst_reader
interface rf_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH-1:0] dout_addr;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  busy;
  logic                  done;

  // The reader side: takes requests, produces the word stream.
  modport master (
    input  start, Addr, len, dout_ready,
    output dout, dout_addr, dout_valid, busy, done
  );

  // The requester/consumer side.
  modport slave (
    output start, Addr, len, dout_ready,
    input  dout, dout_addr, dout_valid, busy, done
  );
endinterface

// File: rtl/rf_burst_reader.sv
// rtl/rf_burst_reader.sv - streams consecutive register-file entries out over valid/ready
module rf_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] from_reg,
  rf_burst_reader_if.master              bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [ADDR_WIDTH-1:0] dout_addr_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  load_start;
  logic                  advance;
  logic                  busy_c, done_c, valid_c;

  // Unpack the flat register bus so words can be picked by index.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign regs[g] = from_reg[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register; reset abandons any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake decode; pointer/data updates are qualified here.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    advance    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    valid_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load_start = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        if (bus.dout_ready) begin
          if (remaining > ONE_CNT) advance    = 1'b1;
          else                     state_next = DONE;
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output word, its index, read pointer and word count. The word is captured
  // only on the loading edge, so it stays frozen through any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      dout_addr_q <= '0;
      ptr         <= '0;
      remaining   <= '0;
    end else if (load_start) begin
      dout_q      <= regs[bus.Addr];
      dout_addr_q <= bus.Addr;
      ptr         <= bus.Addr + ONE_PTR;
      remaining   <= (bus.len == '0) ? FULL_CNT : bus.len;
    end else if (advance) begin
      dout_q      <= regs[ptr];
      dout_addr_q <= ptr;
      ptr         <= ptr + ONE_PTR;
      remaining   <= remaining - ONE_CNT;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_addr  = dout_addr_q;
  assign bus.dout_valid = valid_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_rf_burst_reader.sv
// tb/tb_rf_burst_reader.sv - directed self-checking bench for rf_burst_reader
module tb_rf_burst_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] from_reg;
  logic [31:0]  regs [8];
  int           checks = 0;
  int           errors = 0;

  rf_burst_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  rf_burst_reader dut (
    .clk      (clk),
    .reset    (reset),
    .from_reg (from_reg),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    from_reg = '0;
    for (int i = 0; i < 8; i++) from_reg[i*32 +: 32] = regs[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_regs(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 8; i++) regs[i] = base + step * i;
  endtask

  // Issue a burst with ready held high and follow it to IDLE.
  task automatic run_burst(input int a, input int l);
    int n;
    int busy_cnt;
    int idx;
    n = (l == 0) ? 8 : l;
    busy_cnt = 0;
    bus.start = 1'b1; bus.Addr = 3'(a); bus.len = 4'(l); bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      idx = (a + k) % 8;
      check($sformatf("burst%0d_valid%0d", a, k), 64'(bus.dout_valid), 64'd1);
      check($sformatf("burst%0d_addr%0d", a, k), 64'(bus.dout_addr), 64'(idx));
      check($sformatf("burst%0d_data%0d", a, k), 64'(bus.dout), 64'(regs[idx]));
      check($sformatf("burst%0d_nodone%0d", a, k), 64'(bus.done), 64'd0);
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check($sformatf("burst%0d_done", a), 64'(bus.done), 64'd1);
    check($sformatf("burst%0d_done_novalid", a), 64'(bus.dout_valid), 64'd0);
    if (bus.busy) busy_cnt++;
    @(negedge clk);
    check($sformatf("burst%0d_idle_done", a), 64'(bus.done), 64'd0);
    check($sformatf("burst%0d_idle_busy", a), 64'(bus.busy), 64'd0);
    check($sformatf("burst%0d_busy_cycles", a), 64'(busy_cnt), 64'(n + 1));
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    bus.start = 1'b0; bus.Addr = '0; bus.len = '0; bus.dout_ready = 1'b0;
    load_regs(32'h1000_0000, 32'd1);
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_addr", 64'(bus.dout_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a stalled burst.
    bus.start = 1'b1; bus.Addr = 3'd2; bus.len = 4'd5; bus.dout_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_first_data", 64'(bus.dout), 64'h1000_0002);
    repeat (3) begin
      check("mid_stall_valid", 64'(bus.dout_valid), 64'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 64'(bus.dout_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_dout", 64'(bus.dout), 64'd0);
    bus.dout_ready = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'd0);

    // Basic burst.
    run_burst(0, 3);

    // Wrap-around full sweep with len=0.
    load_regs(32'hC0DE_0000, 32'd3);
    run_burst(5, 0);

    // Backpressure: the captured word must not follow a register write.
    load_regs(32'h1000_0000, 32'd1);
    bus.start = 1'b1; bus.Addr = 3'd3; bus.len = 4'd2; bus.dout_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    regs[3] = 32'hDEAD_BEEF;
    repeat (4) begin
      check("bp_valid", 64'(bus.dout_valid), 64'd1);
      check("bp_dout_frozen", 64'(bus.dout), 64'h1000_0003);
      check("bp_addr", 64'(bus.dout_addr), 64'd3);
      @(negedge clk);
    end
    bus.dout_ready = 1'b1;
    @(negedge clk);
    check("bp_second_data", 64'(bus.dout), 64'h1000_0004);
    check("bp_second_addr", 64'(bus.dout_addr), 64'd4);
    check("bp_second_valid", 64'(bus.dout_valid), 64'd1);
    @(negedge clk);
    check("bp_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("bp_idle", 64'(bus.busy), 64'd0);

    // start ignored in SEND and DONE, honoured in the following IDLE.
    load_regs(32'h1000_0000, 32'd1);
    bus.start = 1'b1; bus.Addr = 3'd0; bus.len = 4'd3; bus.dout_ready = 1'b1;
    @(negedge clk);
    check("ign_w0", 64'(bus.dout), 64'h1000_0000);
    bus.start = 1'b1; bus.Addr = 3'd7; bus.len = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_w1_addr", 64'(bus.dout_addr), 64'd1);
    check("ign_w1_data", 64'(bus.dout), 64'h1000_0001);
    @(negedge clk);
    check("ign_w2_addr", 64'(bus.dout_addr), 64'd2);
    @(negedge clk);
    check("ign_done", 64'(bus.done), 64'd1);
    bus.start = 1'b1; bus.Addr = 3'd7; bus.len = 4'd1;
    @(negedge clk);
    check("ign_idle_valid", 64'(bus.dout_valid), 64'd0);
    check("ign_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_restart_valid", 64'(bus.dout_valid), 64'd1);
    check("ign_restart_addr", 64'(bus.dout_addr), 64'd7);
    check("ign_restart_data", 64'(bus.dout), 64'h1000_0007);
    @(negedge clk);
    check("ign_restart_done", 64'(bus.done), 64'd1);
    @(negedge clk);

    // Single word.
    run_burst(7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
